usreg_preset_clr: RTL and testbench

USREG_PRESET_CLR -- requirements
Module: usreg_preset_clr

---
 rtl/usreg_preset_clr.sv | 105 ++++++++++
 tb/tb_usreg_preset_clr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/usreg_preset_clr.sv
// Universal shift/rotate/count register with asynchronous clear and preset.
// Define USREG_SYNC_CLR_EN to add the synchronous clear input clr_i.
module usreg_preset_clr #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             prst_b_i,
`ifdef USREG_SYNC_CLR_EN
  input  logic             clr_i,
`endif
  input  logic [2:0]       mode_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Returns {wrap, next_q} for one clocked operation.
  function automatic logic [WIDTH:0] next_step(
    input mode_e            m,
    input logic [WIDTH-1:0] q,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] nq;
    logic             wrap;
    nq   = q;
    wrap = 1'b0;
    case (m)
      MODE_HOLD: nq = q;
      MODE_SHR:  nq = {sl, q[WIDTH-1:1]};
      MODE_SHL:  nq = {q[WIDTH-2:0], sr};
      MODE_LOAD: nq = d;
      MODE_ROR:  nq = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  nq = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_INC: begin
        nq   = q + ONE;
        wrap = &q;
      end
      MODE_DEC: begin
        nq   = q - ONE;
        wrap = ~|q;
      end
      default: nq = q;
    endcase
    return {wrap, nq};
  endfunction

  mode_e            mode;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] q_p0;
  logic             tc_p0;
  logic             preset_n;

  assign mode = mode_e'(mode_i);

  always_comb begin
    {wrap_nxt, q_nxt} = next_step(mode, q_p0, sin_l_i, sin_r_i, d_i);
  end

  // Effective preset: active only while clear is released, so it also fires
  // at the moment clear releases with preset still held.
  assign preset_n = ~(rst_b_i & ~prst_b_i);

  // Stage p0: the architectural register.
  always_ff @(posedge clk_i or negedge rst_b_i or negedge preset_n) begin
    if (!rst_b_i) begin
      q_p0  <= '0;
      tc_p0 <= 1'b0;
    end else if (!preset_n) begin
      q_p0  <= PRESET_VAL;
      tc_p0 <= 1'b0;
`ifdef USREG_SYNC_CLR_EN
    end else if (clr_i) begin
      q_p0  <= '0;
      tc_p0 <= 1'b0;
`endif
    end else begin
      q_p0  <= q_nxt;
      tc_p0 <= wrap_nxt;
    end
  end

  assign q_o  = q_p0;
  assign tc_o = tc_p0;

endmodule

// File: tb/tb_usreg_preset_clr.sv
// Directed bench for usreg_preset_clr at WIDTH=8; exercises the clr_i path
// only when USREG_SYNC_CLR_EN is defined.
module tb_usreg_preset_clr;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       prst_b;
  logic       clr;
  logic [2:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] d;
  logic [7:0] q;
  logic       tc;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usreg_preset_clr #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .prst_b_i(prst_b),
`ifdef USREG_SYNC_CLR_EN
    .clr_i   (clr),
`endif
    .mode_i  (mode),
    .sin_l_i (sin_l),
    .sin_r_i (sin_r),
    .d_i     (d),
    .q_o     (q),
    .tc_o    (tc)
  );

  typedef struct {
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic [7:0] d;
    logic [7:0] q;
    logic       tc;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [7:0] exp_q, input logic exp_tc);
    n_vec++;
    if (q !== exp_q || tc !== exp_tc) begin
      n_fail++;
      $display("FAIL %s: got q=%h tc=%b, expected q=%h tc=%b", name, q, tc, exp_q, exp_tc);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [2:0] m, input logic sl, input logic sr, input logic [7:0] dv);
    mode  = m;
    sin_l = sl;
    sin_r = sr;
    d     = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{3'b011, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0};
    tbl[1]  = '{3'b001, 1'b1, 1'b0, 8'h00, 8'hD2, 1'b0};
    tbl[2]  = '{3'b010, 1'b1, 1'b0, 8'hFF, 8'hA4, 1'b0};
    tbl[3]  = '{3'b100, 1'b1, 1'b1, 8'h00, 8'h52, 1'b0};
    tbl[4]  = '{3'b101, 1'b0, 1'b1, 8'hFF, 8'hA4, 1'b0};
    tbl[5]  = '{3'b011, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b0};
    tbl[6]  = '{3'b110, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0};
    tbl[7]  = '{3'b110, 1'b0, 1'b0, 8'h12, 8'h00, 1'b1};
    tbl[8]  = '{3'b111, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1};
    tbl[9]  = '{3'b000, 1'b1, 1'b1, 8'h33, 8'hFF, 1'b0};
    tbl[10] = '{3'b110, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{3'b110, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0};
    tbl[12] = '{3'b111, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[13] = '{3'b111, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1};
    tbl[14] = '{3'b001, 1'b0, 1'b1, 8'hFF, 8'h7F, 1'b0};
    tbl[15] = '{3'b000, 1'b1, 1'b0, 8'h00, 8'h7F, 1'b0};
    tbl[16] = '{3'b010, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0};
    tbl[17] = '{3'b011, 1'b1, 1'b1, 8'h81, 8'h81, 1'b0};
    tbl[18] = '{3'b100, 1'b0, 1'b0, 8'hFF, 8'hC0, 1'b0};
    tbl[19] = '{3'b101, 1'b1, 1'b1, 8'h00, 8'h81, 1'b0};
    tbl[20] = '{3'b001, 1'b0, 1'b1, 8'hFF, 8'h40, 1'b0};
    tbl[21] = '{3'b110, 1'b1, 1'b1, 8'h00, 8'h41, 1'b0};

    rst_b  = 1'b0;
    prst_b = 1'b1;
    clr    = 1'b0;
    mode   = 3'b000;
    sin_l  = 1'b0;
    sin_r  = 1'b0;
    d      = 8'h00;

    #2;
    check("reset_state", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].mode, tbl[i].sl, tbl[i].sr, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].q, tbl[i].tc);
    end

    // Clear between edges: immediate, kills a pending tc pulse, blocks clocks.
    step(3'b011, 1'b0, 1'b0, 8'h00);
    step(3'b111, 1'b0, 1'b0, 8'h00);
    check("dec_wrap_before_clr", 8'hFF, 1'b1);
    #3;
    rst_b = 1'b0;
    #1;
    check("async_clr_immediate", 8'h00, 1'b0);
    step(3'b011, 1'b0, 1'b0, 8'h55);
    check("clk_ignored_in_clr", 8'h00, 1'b0);
    #3;
    rst_b = 1'b1;
    step(3'b110, 1'b0, 1'b0, 8'h00);
    check("first_edge_after_clr", 8'h01, 1'b0);

    // Preset, both asserted, then clear released alone.
    #3;
    prst_b = 1'b0;
    #1;
    check("async_preset_immediate", 8'hFF, 1'b0);
    step(3'b011, 1'b0, 1'b0, 8'h00);
    check("clk_ignored_in_preset", 8'hFF, 1'b0);
    #3;
    rst_b = 1'b0;
    #1;
    check("clr_beats_preset", 8'h00, 1'b0);
    #1;
    rst_b = 1'b1;
    #1;
    check("clr_release_to_preset", 8'hFF, 1'b0);
    prst_b = 1'b1;
    step(3'b110, 1'b0, 1'b0, 8'h00);
    check("inc_from_preset_wrap", 8'h00, 1'b1);

    // Clear asserted just before an incrementing wrap edge.
    step(3'b011, 1'b0, 1'b0, 8'hFF);
    mode = 3'b110;
    @(negedge clk);
    #3;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    check("clr_during_inc_wrap", 8'h00, 1'b0);
    #3;
    rst_b = 1'b1;
    step(3'b000, 1'b0, 1'b0, 8'h00);
    check("hold_after_clr_wrap", 8'h00, 1'b0);

    // Preset asserted just before an incrementing wrap edge.
    step(3'b011, 1'b0, 1'b0, 8'hFF);
    mode = 3'b110;
    @(negedge clk);
    #3;
    prst_b = 1'b0;
    @(posedge clk);
    #1;
    check("preset_during_inc_wrap", 8'hFF, 1'b0);
    #3;
    prst_b = 1'b1;

`ifdef USREG_SYNC_CLR_EN
    step(3'b011, 1'b0, 1'b0, 8'h3C);
    check("load_before_sync_clr", 8'h3C, 1'b0);
    clr = 1'b1;
    step(3'b011, 1'b0, 1'b0, 8'hAA);
    check("sync_clr_over_load", 8'h00, 1'b0);
    clr = 1'b0;
    step(3'b111, 1'b0, 1'b0, 8'h00);
    check("dec_wrap_before_sync_clr", 8'hFF, 1'b1);
    clr = 1'b1;
    step(3'b111, 1'b0, 1'b0, 8'h00);
    check("sync_clr_kills_tc", 8'h00, 1'b0);
    #3;
    prst_b = 1'b0;
    step(3'b011, 1'b0, 1'b0, 8'h00);
    check("preset_beats_sync_clr", 8'hFF, 1'b0);
    #3;
    prst_b = 1'b1;
    clr    = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
